// File: rtl/serial_frame_ctrl.sv
// ---------------------------------------------------------------------------
// serial_frame_ctrl
//
// Purpose:
//   Hunts a 1-bit serial stream for a sync pattern (overlapping detection),
//   then captures a fixed-length payload and presents it to a word-level
//   consumer over a valid/ready handshake. Owns all framing state.
//
// Parameters:
//   PAT_LEN  sync pattern length in bits (2..16)
//   PAT      sync pattern, first received bit is the MSB
//   PAY_LEN  payload length in bits (1..32)
//
// Ports:
//   clk      in   1        single clock, everything sampled on posedge
//   rst      in   1        synchronous active-high reset, highest priority
//   x        in   1        serial data, one bit per clock
//   ready    in   1        consumer accepts data when valid && ready
//   data     out  PAY_LEN  captured payload, first payload bit is the MSB
//   valid    out  1        data holds an unconsumed frame
//   sync     out  1        one-cycle pulse after the last pattern bit
//   overrun  out  1        sticky: a frame was dropped because valid was
//                          held without ready
//   state    out  2        0 = HUNT, 1 = LOAD (FSM state, also for checkers)
//
// Handshake: a transfer happens at any posedge where valid && ready. valid
// rises only when a frame completes; data never changes while valid is high
// and unconsumed; ready is ignored while valid is low.
// ---------------------------------------------------------------------------
module serial_frame_ctrl #(
  parameter int unsigned          PAT_LEN = 5,
  parameter logic [PAT_LEN-1:0]   PAT     = 5'b11011,
  parameter int unsigned          PAY_LEN = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               x,
  input  logic               ready,
  output logic [PAY_LEN-1:0] data,
  output logic               valid,
  output logic               sync,
  output logic               overrun,
  output logic [1:0]         state
);

  localparam int unsigned CW  = $clog2(PAY_LEN + 1);
  localparam int unsigned HW  = $clog2(PAT_LEN);
  // Only PAY_LEN-1 payload bits need storing: the last bit is taken live
  // from x on the completing edge.
  localparam int unsigned SHW = (PAY_LEN > 1) ? PAY_LEN - 1 : 1;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    LOAD = 2'd1
  } state_e;

  state_e               state_q, state_d;
  // Window keeps the previous PAT_LEN-1 bits; the newest bit is x itself.
  logic [PAT_LEN-2:0]   win_q, win_d;
  logic [HW-1:0]        hist_q, hist_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [SHW-1:0]       sh_q, sh_d;
  logic [PAY_LEN-1:0]   data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 sync_q, sync_d;
  logic                 overrun_q, overrun_d;

  logic [PAT_LEN-1:0]   win_full;
  logic [PAY_LEN-1:0]   frame_w;

  assign win_full = {win_q, x};

  generate
    if (PAY_LEN == 1) begin : g_pay_one
      assign frame_w = x;
    end else begin : g_pay_many
      assign frame_w = {sh_q, x};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= HUNT;
      win_q     <= '0;
      hist_q    <= '0;
      cnt_q     <= '0;
      sh_q      <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      sync_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      hist_q    <= hist_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      sync_q    <= sync_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    hist_d    = hist_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    data_d    = data_q;
    valid_d   = valid_q;
    sync_d    = 1'b0;
    overrun_d = overrun_q;

    // Consumption; a frame completing on the same edge overrides below.
    if (valid_q && ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      HUNT: begin
        win_d = win_full[PAT_LEN-2:0];
        if (hist_q < HW'(PAT_LEN - 1)) begin
          hist_d = hist_q + HW'(1);
        end
        // hist guards against matching on bits left over from reset or
        // from before the last frame.
        if ((hist_q == HW'(PAT_LEN - 1)) && (win_full == PAT)) begin
          state_d = LOAD;
          sync_d  = 1'b1;
          cnt_d   = '0;
        end
      end

      LOAD: begin
        sh_d  = frame_w[SHW-1:0];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(PAY_LEN - 1)) begin
          // Payload bits are discarded from the search: window and
          // history restart from empty.
          state_d = HUNT;
          win_d   = '0;
          hist_d  = '0;
          if (!valid_q || ready) begin
            data_d  = frame_w;
            valid_d = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = HUNT;
        win_d   = '0;
        hist_d  = '0;
      end
    endcase
  end

  assign data    = data_q;
  assign valid   = valid_q;
  assign sync    = sync_q;
  assign overrun = overrun_q;
  assign state   = state_q;

endmodule

// File: tb/tb_serial_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_frame_ctrl
//
// Self-checking bench for serial_frame_ctrl. A behavioural model based on
// bit queues tracks the expected outputs every cycle; a table covers the
// basic frame, hand sequences cover overlap, pattern-in-payload,
// backpressure and reset mid-frame, and a random phase finishes the run.
// ---------------------------------------------------------------------------
module tb_serial_frame_ctrl;

  localparam int unsigned        PAT_LEN = 5;
  localparam logic [PAT_LEN-1:0] PAT     = 5'b11011;
  localparam int unsigned        PAY_LEN = 8;

  // ---------------- clock / reset / DUT ----------------
  logic               clk = 1'b0;
  logic               rst;
  logic               x;
  logic               ready;
  logic [PAY_LEN-1:0] data;
  logic               valid;
  logic               sync;
  logic               overrun;
  logic [1:0]         state;

  always #5 clk = ~clk;

  serial_frame_ctrl #(
    .PAT_LEN (PAT_LEN),
    .PAT     (PAT),
    .PAY_LEN (PAY_LEN)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .x       (x),
    .ready   (ready),
    .data    (data),
    .valid   (valid),
    .sync    (sync),
    .overrun (overrun),
    .state   (state)
  );

  // ---------------- bookkeeping ----------------
  int checks     = 0;
  int failures   = 0;
  int cyc        = 0;
  int sync_seen  = 0;
  int valid_seen = 0;

  // ---------------- reference model ----------------
  bit                 hb_q[$];   // bits received since entering hunt
  bit                 pb_q[$];   // payload bits of the frame in progress
  logic [PAY_LEN-1:0] exp_q[$];  // frames expected to appear on data
  logic [1:0]         m_state;
  logic               m_valid;
  logic               m_sync;
  logic               m_over;
  logic [PAY_LEN-1:0] m_data;
  logic               m_loaded;

  task automatic model_edge(input logic xi, input logic ri, input logic rsti);
    logic               consumed;
    logic               match;
    logic [PAT_LEN-1:0] pat_v;
    logic [PAY_LEN-1:0] v;
    pat_v    = PAT;
    m_loaded = 1'b0;
    if (rsti) begin
      m_state = 2'd0;
      m_valid = 1'b0;
      m_sync  = 1'b0;
      m_over  = 1'b0;
      m_data  = '0;
      hb_q.delete();
      pb_q.delete();
    end else begin
      consumed = m_valid && ri;
      m_sync   = 1'b0;
      if (m_state == 2'd0) begin
        hb_q.push_back(xi);
        if (hb_q.size() > PAT_LEN) void'(hb_q.pop_front());
        if (hb_q.size() == PAT_LEN) begin
          match = 1'b1;
          for (int i = 0; i < int'(PAT_LEN); i++)
            if (hb_q[i] != pat_v[int'(PAT_LEN)-1-i]) match = 1'b0;
          if (match) begin
            m_state = 2'd1;
            m_sync  = 1'b1;
            pb_q.delete();
          end
        end
      end else begin
        pb_q.push_back(xi);
        if (pb_q.size() == PAY_LEN) begin
          v = '0;
          for (int i = 0; i < int'(PAY_LEN); i++) v[int'(PAY_LEN)-1-i] = pb_q[i];
          m_state = 2'd0;
          hb_q.delete();
          if (!m_valid || ri) begin
            m_data   = v;
            m_valid  = 1'b1;
            consumed = 1'b0;
            m_loaded = 1'b1;
            exp_q.push_back(v);
          end else begin
            m_over = 1'b1;
          end
        end
      end
      if (consumed) m_valid = 1'b0;
    end
  endtask

  // ---------------- checker ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=0x%0h required=0x%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic xi, input logic ri, input logic rsti);
    x     = xi;
    ready = ri;
    rst   = rsti;
    @(posedge clk);
    cyc++;
    model_edge(xi, ri, rsti);
    #1;
    if (sync === 1'b1)  sync_seen++;
    if (valid === 1'b1) valid_seen++;
    chk("model_state",   32'(state),   32'(m_state));
    chk("model_sync",    32'(sync),    32'(m_sync));
    chk("model_valid",   32'(valid),   32'(m_valid));
    chk("model_overrun", 32'(overrun), 32'(m_over));
    chk("model_data",    32'(data),    32'(m_data));
    if (m_loaded) begin
      if (exp_q.size() == 0) chk("frame_queue_empty", 32'd1, 32'd0);
      else chk("frame", 32'(data), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic send_pat(input logic ri);
    logic [PAT_LEN-1:0] p;
    p = PAT;
    for (int i = int'(PAT_LEN) - 1; i >= 0; i--) step(p[i], ri, 1'b0);
  endtask

  task automatic send_byte(input logic [PAY_LEN-1:0] b, input logic ri);
    for (int i = int'(PAY_LEN) - 1; i >= 0; i--) step(b[i], ri, 1'b0);
  endtask

  // ---------------- basic-frame vector table ----------------
  typedef struct {
    logic       x;
    logic [1:0] e_state;
    logic       e_sync;
    logic       e_valid;
    logic [7:0] e_data;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int s0;
    int v0;
    logic [PAY_LEN-1:0] second;
    rst   = 1'b1;
    x     = 1'b0;
    ready = 1'b0;

    // Reset held for two cycles with random inputs.
    for (int i = 0; i < 2; i++) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
    chk("rst_state",   32'(state),   32'd0);
    chk("rst_valid",   32'(valid),   32'd0);
    chk("rst_sync",    32'(sync),    32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_data",    32'(data),    32'd0);

    // Basic frame 11011 + A5 with ready=1, plus one idle cycle.
    tbl[0]  = '{1'b1, 2'd0, 1'b0, 1'b0, 8'h00};
    tbl[1]  = '{1'b1, 2'd0, 1'b0, 1'b0, 8'h00};
    tbl[2]  = '{1'b0, 2'd0, 1'b0, 1'b0, 8'h00};
    tbl[3]  = '{1'b1, 2'd0, 1'b0, 1'b0, 8'h00};
    tbl[4]  = '{1'b1, 2'd1, 1'b1, 1'b0, 8'h00};
    tbl[5]  = '{1'b1, 2'd1, 1'b0, 1'b0, 8'h00};
    tbl[6]  = '{1'b0, 2'd1, 1'b0, 1'b0, 8'h00};
    tbl[7]  = '{1'b1, 2'd1, 1'b0, 1'b0, 8'h00};
    tbl[8]  = '{1'b0, 2'd1, 1'b0, 1'b0, 8'h00};
    tbl[9]  = '{1'b0, 2'd1, 1'b0, 1'b0, 8'h00};
    tbl[10] = '{1'b1, 2'd1, 1'b0, 1'b0, 8'h00};
    tbl[11] = '{1'b0, 2'd1, 1'b0, 1'b0, 8'h00};
    tbl[12] = '{1'b1, 2'd0, 1'b0, 1'b1, 8'hA5};
    tbl[13] = '{1'b0, 2'd0, 1'b0, 1'b0, 8'hA5};
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].x, 1'b1, 1'b0);
      chk("tbl_state", 32'(state), 32'(tbl[i].e_state));
      chk("tbl_sync",  32'(sync),  32'(tbl[i].e_sync));
      chk("tbl_valid", 32'(valid), 32'(tbl[i].e_valid));
      chk("tbl_data",  32'(data),  32'(tbl[i].e_data));
    end

    // Overlap: 1,1,1,0,1,1 matches on the 6th bit.
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("ovl_nosync_5th", 32'(sync), 32'd0);
    step(1'b1, 1'b1, 1'b0);
    chk("ovl_sync_6th", 32'(sync), 32'd1);
    send_byte(8'h3C, 1'b1);
    chk("ovl_valid", 32'(valid), 32'd1);
    chk("ovl_data",  32'(data),  32'h3C);

    // Pattern inside payload must not trigger a second detection.
    step(1'b0, 1'b0, 1'b1);
    s0 = sync_seen;
    send_pat(1'b1);
    send_byte(8'hDB, 1'b1);
    chk("pip_data",  32'(data),  32'hDB);
    chk("pip_valid", 32'(valid), 32'd1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
    chk("pip_one_sync", 32'(sync_seen - s0), 32'd1);
    chk("pip_state",    32'(state),          32'd0);

    // Backpressure: second frame is dropped and overrun sticks.
    step(1'b0, 1'b0, 1'b1);
    send_pat(1'b0);
    send_byte(8'h11, 1'b0);
    chk("bp_valid1",   32'(valid),   32'd1);
    chk("bp_data1",    32'(data),    32'h11);
    chk("bp_overrun1", 32'(overrun), 32'd0);
    send_pat(1'b0);
    second = 8'h22;
    for (int i = int'(PAY_LEN) - 1; i >= 1; i--) step(second[i], 1'b0, 1'b0);
    chk("bp_overrun_early", 32'(overrun), 32'd0);
    step(second[0], 1'b0, 1'b0);
    chk("bp_overrun2", 32'(overrun), 32'd1);
    chk("bp_data2",    32'(data),    32'h11);
    chk("bp_valid2",   32'(valid),   32'd1);
    step(1'b0, 1'b1, 1'b0);
    chk("bp_valid_clr",    32'(valid),   32'd0);
    chk("bp_overrun_held", 32'(overrun), 32'd1);
    step(1'b0, 1'b0, 1'b0);
    chk("bp_overrun_sticky", 32'(overrun), 32'd1);

    // Reset mid-frame abandons the partial payload.
    step(1'b0, 1'b0, 1'b1);
    v0 = valid_seen;
    send_pat(1'b1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    chk("rmf_state",   32'(state),   32'd0);
    chk("rmf_valid",   32'(valid),   32'd0);
    chk("rmf_overrun", 32'(overrun), 32'd0);
    send_pat(1'b1);
    send_byte(8'h5A, 1'b1);
    chk("rmf_one_valid", 32'(valid_seen - v0), 32'd1);
    chk("rmf_data",      32'(data),            32'h5A);
    chk("rmf_valid2",    32'(valid),           32'd1);

    // Random phase against the model.
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4000; i++) begin
      step(1'($urandom_range(0, 1)),
           1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 399) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_frame_ctrl.md
# serial_frame_ctrl

Frame controller for the serial input path. It hunts the 1-bit stream `x` for a sync pattern using overlapping detection, the same scheme as our 11011 detector. On a match it sequences capture of a fixed-length payload and hands the word to downstream logic over a valid/ready handshake. It sits between the serial pin sampler and the word-level consumer, and it owns all framing state.

## Interface
- `PAT`, default 5'b11011: sync pattern. The first bit received is the MSB.
- `PAT_LEN`, default 5: pattern length in bits, 2..16.
- `PAY_LEN`, default 8: payload length in bits, 1..32.
- `clk`  in  1: single clock. Every signal is sampled on the posedge.
- `rst`  in  1: synchronous, active-high reset.
- `x`  in  1: serial data, one bit per clock.
- `ready`  in  1: consumer accepts `data` when `valid && ready` at a posedge.
- `data`  out  PAY_LEN: captured payload. The first payload bit is the MSB.
- `valid`  out  1: `data` holds an unconsumed frame.
- `sync`  out  1: one-cycle pulse, registered, high in the cycle after the last pattern bit is sampled.
- `overrun`  out  1: sticky. A frame completed while `valid` was high and not being consumed.
- `state`  out  2: 0 = HUNT, 1 = LOAD. Codes 2 and 3 are unused.

## Operation
- Reset values: `state` = HUNT, `data` = 0, `valid` = 0, `sync` = 0, `overrun` = 0. The window register, history counter and bit counter are also 0.
- HUNT:
  - Shift `x` into a PAT_LEN-bit window each clock: win <= {win[PAT_LEN-2:0], x}.
  - `hist` counts bits received since entering HUNT and saturates at PAT_LEN-1.
  - Match condition: `hist == PAT_LEN-1` and `{win[PAT_LEN-2:0], x} == PAT`.
  - On a match: `state` <= LOAD, `sync` <= 1, `cnt` <= 0.
  - Detection is overlapping. A failed partial match never discards bits, so 1,1,1,0,1,1 matches on the 6th bit.
- LOAD:
  - Each clock: sh <= {sh[PAY_LEN-2:0], x} and `cnt` <= `cnt`+1. `cnt` is $clog2(PAY_LEN+1) bits wide.
  - On the clock where `cnt == PAY_LEN-1`, the frame completes:
    - `state` <= HUNT, window <= 0, `hist` <= 0.
    - Payload bits never count toward the next sync search.
    - If `valid` is 0, or `ready` is 1 at this edge: `data` <= {sh[PAY_LEN-2:0], x} and `valid` <= 1.
    - Otherwise the frame is dropped. `data` is unchanged and `overrun` <= 1.
- Handshake:
  - `valid && ready` at a posedge clears `valid`, unless a frame completes at the same edge. In that case the new data loads and `valid` stays 1.
  - `data` is stable while `valid` is high and unconsumed.
  - `ready` is ignored while `valid` is low.
- `overrun` clears only on `rst`.
- `sync` is high for exactly one cycle per detected pattern. It is never asserted in LOAD.
- `rst` has priority over every other event. Reset during LOAD abandons the partial frame with no `valid` and no `overrun`.

## Timing
- Latency from pattern detection to data:
  - The last pattern bit is sampled at edge N.
  - `sync` is high during N..N+1.
  - Payload bits are sampled at edges N+1 .. N+PAY_LEN.
  - `valid` rises after edge N+PAY_LEN.
- Minimum frame spacing is PAY_LEN+PAT_LEN cycles: the next match can occur no earlier than edge N+PAY_LEN+PAT_LEN.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with random `x` and `ready`. Required: `state`=0, `valid`=0, `sync`=0, `overrun`=0, `data`=0.
- Basic frame: with `ready`=1, send 1,1,0,1,1 then 1,0,1,0,0,1,0,1. Required:
  - `sync` pulses once, the cycle after the 5th bit.
  - `valid`=1 with `data`=8'hA5 for one cycle, after the 13th bit.
  - `state` goes 0→1→0.
- Overlap: send 1,1,1,0,1,1 then 8'h3C. Required: `sync` after the 6th bit (not the 5th) and `data`=8'h3C.
- Pattern inside payload: send 11011, then 8'b11011011, then 0,0,0. Required: one `sync` only, `data`=8'hDB, and no second detection.
- Backpressure: with `ready`=0, send frame 8'h11 then frame 8'h22. Required:
  - `data` stays 8'h11 and `valid` stays 1.
  - `overrun` rises after the second frame's last bit.
  - Raising `ready` for 1 cycle clears `valid`. `overrun` stays 1.
- Reset mid-frame: after 11011 and 3 payload bits, pulse `rst` for 1 cycle, then send 11011 + 8'h5A. Required: no `valid` from the aborted frame, then `valid` with `data`=8'h5A.
